// File: rtl/benes_route_sequencer_pkg.sv
// Shared sizes and types for the Benes route sequencer.
// Holds switch/stage geometry, route config and command bundles.
package benes_route_sequencer_pkg;

    localparam int SWITCH_NUM = 16;
    localparam int STAGE_NUM  = 9;
    localparam int CFG_DEPTH  = 16;
    localparam int LEN_W      = 16;

    localparam int ID_W  = $clog2(CFG_DEPTH);
    localparam int STG_W = $clog2(STAGE_NUM);

    localparam logic [STG_W-1:0] STG_MAX   = STG_W'(STAGE_NUM - 1);
    localparam logic [LEN_W-1:0] DRAIN_LEN = LEN_W'(STAGE_NUM - 1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    // One switch row per Benes stage.
    typedef logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] route_cfg_t;

    typedef struct packed {
        logic [ID_W-1:0]  r2m_id;
        logic [ID_W-1:0]  m2r_id;
        logic [LEN_W-1:0] len;
    } route_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/route_skew_line.sv
// Per-stage valid skew: valid_o[s] is in_i delayed by s+1 cycles.
// Ports: clk, rst_n, in_i (stage-0 valid next cycle), valid_o[0..STAGE_NUM-1].
module route_skew_line
    import benes_route_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_i,
    output logic [STAGE_NUM-1:0] valid_o
);

    logic [STAGE_NUM-1:0] valid_q;
    logic [STAGE_NUM-1:0] valid_d;

    assign valid_d = {valid_q[STAGE_NUM-2:0], in_i};
    assign valid_o = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/benes_route_sequencer.sv
// Sequences per-stage Benes switch settings for the R2M and M2R networks.
// Ports: cfg_* table write, start_* command, busy/done/start_err, o_*_select.
module benes_route_sequencer
    import benes_route_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic                  cfg_net,
    input  logic [ID_W-1:0]       cfg_addr,
    input  logic [STG_W-1:0]      cfg_stage,
    input  logic [SWITCH_NUM-1:0] cfg_bits,
    input  logic                  start,
    input  logic [ID_W-1:0]       start_r2m_id,
    input  logic [ID_W-1:0]       start_m2r_id,
    input  logic [LEN_W-1:0]      start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err,
    output route_cfg_t            o_module_select,
    output route_cfg_t            o_slot_select
);

    route_cfg_t tbl_q [2][CFG_DEPTH];

    route_cmd_t cmd;

    seq_state_t state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic snap_load;

    route_cfg_t snap_r2m_q, snap_m2r_q;

    logic [STAGE_NUM-1:0] valid;
    logic run_d;

    assign cmd = '{r2m_id: start_r2m_id,
                   m2r_id: start_m2r_id,
                   len:    start_len};

    // Config table; rows past the last stage are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 2; n++) begin
                for (int a = 0; a < CFG_DEPTH; a++) begin
                    tbl_q[n][a] <= '0;
                end
            end
        end else if (cfg_we && (cfg_stage <= STG_MAX)) begin
            tbl_q[cfg_net][cfg_addr][cfg_stage] <= cfg_bits;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        snap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cmd.len != '0) begin
                        state_d   = ST_RUN;
                        cnt_d     = cmd.len;
                        snap_load = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                err_d = start;
                if (cnt_q == LEN_ONE) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LEN;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            ST_DRAIN: begin
                err_d = start;
                // Last drain cycle: the deepest stage has just emptied.
                if (cnt_q == LEN_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Snapshot reads the table before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r2m_q <= '0;
            snap_m2r_q <= '0;
        end else if (snap_load) begin
            snap_r2m_q <= tbl_q[0][cmd.r2m_id];
            snap_m2r_q <= tbl_q[1][cmd.m2r_id];
        end
    end

    assign run_d = (state_d == ST_RUN);

    route_skew_line u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (run_d),
        .valid_o (valid)
    );

    // Flop-to-output through one gate level; idle rows read as straight.
    always_comb begin
        o_module_select = '0;
        o_slot_select   = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (valid[s]) begin
                o_module_select[s] = snap_r2m_q[s];
                o_slot_select[s]   = snap_m2r_q[s];
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign start_err = err_q;

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Randomized and directed checks of benes_route_sequencer
// against a cycle-window reference model.
module tb_benes_route_sequencer;
    import benes_route_sequencer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cfg_we = 1'b0;
    logic                  cfg_net = 1'b0;
    logic [ID_W-1:0]       cfg_addr = '0;
    logic [STG_W-1:0]      cfg_stage = '0;
    logic [SWITCH_NUM-1:0] cfg_bits = '0;
    logic                  start = 1'b0;
    logic [ID_W-1:0]       start_r2m_id = '0;
    logic [ID_W-1:0]       start_m2r_id = '0;
    logic [LEN_W-1:0]      start_len = '0;
    logic                  busy, done, start_err;
    route_cfg_t            o_module_select, o_slot_select;

    benes_route_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_net         (cfg_net),
        .cfg_addr        (cfg_addr),
        .cfg_stage       (cfg_stage),
        .cfg_bits        (cfg_bits),
        .start           (start),
        .start_r2m_id    (start_r2m_id),
        .start_m2r_id    (start_m2r_id),
        .start_len       (start_len),
        .busy            (busy),
        .done            (done),
        .start_err       (start_err),
        .o_module_select (o_module_select),
        .o_slot_select   (o_slot_select)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic [15:0] tbl [2][16][9];
    logic [15:0] snap_r [9];
    logic [15:0] snap_m [9];
    bit act = 0;
    int ts = 0;
    int rl = 0;
    int done_at = -1;
    int err_at = -1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    function automatic bit exp_busy(int c);
        return act && c >= ts + 1 && c <= ts + rl + STAGE_NUM - 1;
    endfunction

    function automatic logic [15:0] exp_stage(bit m2r, int s);
        int k;
        k = cyc - ts - 1 - s;
        if (act && k >= 0 && k < rl)
            return m2r ? snap_m[s] : snap_r[s];
        return 16'h0;
    endfunction

    task automatic check_all();
        chk("busy", 32'(busy), 32'(exp_busy(cyc)));
        chk("done", 32'(done), 32'(cyc == done_at));
        chk("start_err", 32'(start_err), 32'(cyc == err_at));
        for (int s = 0; s < STAGE_NUM; s++) begin
            chk($sformatf("module_select[%0d]", s),
                32'(o_module_select[s]), 32'(exp_stage(0, s)));
            chk($sformatf("slot_select[%0d]", s),
                32'(o_slot_select[s]), 32'(exp_stage(1, s)));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(start_err), 0);
        for (int s = 0; s < STAGE_NUM; s++) begin
            chk($sformatf("%s_mod[%0d]", tag, s), 32'(o_module_select[s]), 0);
            chk($sformatf("%s_slot[%0d]", tag, s), 32'(o_slot_select[s]), 0);
        end
    endtask

    task automatic model_clear();
        for (int n = 0; n < 2; n++)
            for (int a = 0; a < 16; a++)
                for (int s = 0; s < 9; s++)
                    tbl[n][a][s] = 16'h0;
        act = 0;
        done_at = -1;
        err_at = -1;
    endtask

    // Apply the inputs of the current cycle to the model at the edge.
    task automatic model_edge();
        if (start) begin
            if (exp_busy(cyc)) begin
                err_at = cyc + 1;
            end else if (start_len == 0) begin
                done_at = cyc + 1;
            end else begin
                act = 1;
                ts = cyc;
                rl = int'(start_len);
                for (int s = 0; s < 9; s++) begin
                    snap_r[s] = tbl[0][start_r2m_id][s];
                    snap_m[s] = tbl[1][start_m2r_id][s];
                end
                done_at = cyc + rl + STAGE_NUM;
            end
        end
        if (cfg_we && cfg_stage < STAGE_NUM)
            tbl[cfg_net][cfg_addr][cfg_stage] = cfg_bits;
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wr(input bit n, input int a, input int s,
                      input logic [15:0] b);
        cfg_we = 1; cfg_net = n;
        cfg_addr = ID_W'(a); cfg_stage = STG_W'(s); cfg_bits = b;
        step();
        cfg_we = 0;
    endtask

    task automatic go(input int r, input int m, input int len);
        start = 1;
        start_r2m_id = ID_W'(r); start_m2r_id = ID_W'(m);
        start_len = LEN_W'(len);
        step();
        start = 0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (cyc != done_at && guard < 60) begin
            step();
            guard++;
        end
        if (cyc != done_at) begin
            checks++;
            errors++;
            $error("FAIL done_wait: cycle %0d, done expected at %0d",
                   cyc, done_at);
        end
    endtask

    initial begin
        model_clear();
        #2;
        check_zero("reset");
        #10 rst_n = 1;
        @(posedge clk);
        #1;
        cyc = 0;

        // Idle, with a write that must not move outputs.
        repeat (10) step();
        wr(0, 7, 2, 16'h1234);
        repeat (9) step();

        // Directed configs; stage 12 row is dropped.
        for (int s = 0; s < 9; s++) wr(0, 3, s, 16'h0001 << s);
        for (int s = 0; s < 9; s++) wr(1, 5, s, 16'hFFFF);
        wr(0, 3, 12, 16'hDEAD);
        step();

        // Main run; overlap start at t+5; overwrite at t+2.
        go(3, 5, 4);
        step();
        wr(0, 3, 8, 16'hAAAA);
        step();
        step();
        go(3, 5, 4);
        wait_done();
        repeat (3) step();

        // Fresh start picks up the overwritten row.
        go(3, 5, 3);
        wait_done();
        // Back-to-back start in the done cycle.
        go(3, 5, 2);
        wait_done();
        step();

        // Zero-length start.
        go(3, 5, 0);
        repeat (4) step();

        // Reset mid-run.
        go(3, 5, 6);
        step();
        step();
        #1 rst_n = 0;
        #1 check_zero("abort");
        model_clear();
        #1 rst_n = 1;
        repeat (3) step();
        for (int s = 0; s < 9; s++) wr(0, 1, s, 16'($urandom));
        for (int s = 0; s < 9; s++) wr(1, 2, s, 16'($urandom));
        go(1, 2, 5);
        wait_done();
        step();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cfg_we = ($urandom_range(0, 2) == 0);
            cfg_net = 1'($urandom);
            cfg_addr = ID_W'($urandom_range(0, 3));
            cfg_stage = STG_W'($urandom_range(0, 11));
            cfg_bits = 16'($urandom);
            start = ($urandom_range(0, 7) == 0);
            start_r2m_id = ID_W'($urandom_range(0, 3));
            start_m2r_id = ID_W'($urandom_range(0, 3));
            start_len = LEN_W'($urandom_range(0, 6));
            step();
        end
        cfg_we = 0;
        start = 0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/benes_route_sequencer.md
Name: benes_route_sequencer

Overview:
Supplies the per-stage switch settings for the Benes interconnect between buffer RAM slots and FHE modules. It drives both the RAM-to-module network and the module-to-RAM network. It holds a table of routing configurations written by the controller. On a start command it snapshots one configuration per network and presents it for a programmed number of cycles. Stage s is skewed by s cycles so that each stage's setting lines up with data moving through the per-stage-registered network.

Parameters:
SWITCH_NUM, 16, switches per Benes stage (SIZE/2).
STAGE_NUM, 9, Benes stages (2*log2(SIZE)-1).
CFG_DEPTH, 16, routing configurations stored per network.
LEN_W, 16, width of the run-length field.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  table write strobe
cfg_net  in  1  0 = R2M table, 1 = M2R table
cfg_addr  in  $clog2(CFG_DEPTH)  configuration index
cfg_stage  in  $clog2(STAGE_NUM)  stage row written
cfg_bits  in  SWITCH_NUM  switch bits for that row
start  in  1  start request
start_r2m_id  in  $clog2(CFG_DEPTH)  R2M configuration to run
start_m2r_id  in  $clog2(CFG_DEPTH)  M2R configuration to run
start_len  in  LEN_W  cycles for which the route is held
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
start_err  out  1  one-cycle pulse when start is rejected
o_module_select  out  SWITCH_NUM x [0:STAGE_NUM-1]  R2M switch settings
o_slot_select  out  SWITCH_NUM x [0:STAGE_NUM-1]  M2R switch settings

Behaviour:
- Reset (asynchronous): both tables cleared to 0; all outputs 0; FSM goes to IDLE; all skew pipelines cleared. Reset during RUN or DRAIN aborts the sequence immediately and produces no done pulse.
- Table write: when cfg_we=1, the row (cfg_net, cfg_addr, cfg_stage) is written on the clock edge. A cfg_stage value >= STAGE_NUM is ignored. Writes are allowed in any state. The active route is a snapshot taken at start, so a write to an in-use entry does not affect the running sequence.
- FSM states:
  - IDLE: start=1 with start_len>0 → RUN. On that edge, snapshot both configs and load a counter with start_len.
  - IDLE: start=1 with start_len=0 → no RUN; done pulses in the next cycle.
  - RUN: the counter decrements each cycle. When it reaches 1 → DRAIN, with the drain counter loaded with STAGE_NUM-1.
  - DRAIN: the counter decrements. At 0 → IDLE, and done=1 in the first IDLE cycle.
- Timing for a start accepted in cycle t with length L:
  - valid[0] is high in cycles t+1 .. t+L.
  - valid[s] is valid[0] delayed by s cycles.
  - o_module_select[s] = valid[s] ? snap_r2m[s] : 0, registered. o_slot_select follows the same rule.
  - busy is high in cycles t+1 .. t+L+STAGE_NUM-1.
  - done is high in cycle t+L+STAGE_NUM.
- Idle outputs are all-zero (straight-through switches).
- start while busy=1: ignored; start_err pulses in the next cycle; the running sequence is unaffected.
- start in the same cycle as done: accepted, with back-to-back skew and no overlap error.
- A write and a start to the same entry in the same cycle: the snapshot takes the old contents (the write lands on the same edge).

Decomposition:
- FHE_ALU_PKG owns SWITCH_NUM and STAGE_NUM.
- Add to the package: typedef route_cfg_t (logic [SWITCH_NUM-1:0] array [0:STAGE_NUM-1]) and typedef route_cmd_t (r2m_id, m2r_id, len).
- One sub-module: route_skew_line. It is a STAGE_NUM-deep shift register of the valid bit giving valid[0..STAGE_NUM-1], and is instantiated once and shared by both networks.

Test Plan:
- Reset then idle: all outputs 0, busy=0 for 20 cycles; a table write during idle causes no output change.
- Write R2M cfg 3 with stage s bits = 16'h0001<<s and M2R cfg 5 with bits = 16'hFFFF; start at t (ids 3/5, len 4) → o_module_select[0]=0x0001 in cycles t+1..t+4; [8]=0x0100 in t+9..t+12; o_slot_select follows the same windows with 0xFFFF; done at t+13; busy t+1..t+12.
- Start with len=0 → busy never rises; done pulses at t+1; outputs stay 0.
- Start again at t+5 during a len-4 run → start_err at t+6; original done still at t+13.
- At t+2 of a run, overwrite cfg 3 stage 8 with 0xAAAA → stage 8 still outputs 0x0100; a fresh start afterwards outputs 0xAAAA.
- Assert rst_n low at t+3 of a run → outputs 0 immediately, no done; after release, a new start runs normally.
